// File: rtl/note_spawner.sv
// note_spawner: beat and note generator for the rhythm-game LED matrix.
//
// Divides clk into scroll ticks (en) whose period follows the player speed.
// Each tick of a song draws a note pattern from a 16-bit LFSR. The selected
// lanes pulse r1..r4 one cycle after en. A song runs NUM_BEATS spawn ticks,
// then DRAIN_TICKS silent ticks so the playfield empties, then reports done.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   start      in   begin song (level; honoured in IDLE/DONE only)
//   pause      in   level; freezes the tick counter while high
//   speed      in   [9:0] player speed, larger = faster
//   en         out  one-cycle scroll strobe
//   r1..r4     out  lane spawn pulses (LFSR nibbles 0..3)
//   busy       out  high while a song is running or draining
//   done       out  high once the song has drained
//   beat_count out  [15:0] spawn ticks elapsed this song
module note_spawner #(
  parameter int          TICK_SHIFT  = 14,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          DENSITY     = 4,
  parameter int          MIN_GAP     = 1,
  parameter int          NUM_BEATS   = 64,
  parameter int          DRAIN_TICKS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic [9:0]  speed,
  output logic        en,
  output logic        r1,
  output logic        r2,
  output logic        r3,
  output logic        r4,
  output logic        busy,
  output logic        done,
  output logic [15:0] beat_count
);

  localparam int CW  = 10 + TICK_SHIFT;
  localparam int CDW = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);

  localparam logic [15:0]    SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0]    NB       = 16'(NUM_BEATS);
  localparam logic [15:0]    DT       = 16'(DRAIN_TICKS);
  localparam logic [CDW-1:0] GAP      = CDW'(MIN_GAP);
  localparam logic [4:0]     DENS     = 5'(DENSITY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  // Last count value of a period: ((1024 - speed) << TICK_SHIFT) - 1.
  // The period is at least 1, so the subtraction never underflows.
  function automatic logic [CW-1:0] period_m1(input logic [9:0] spd);
    logic [CW:0] p;
    p = (CW+1)'(11'd1024 - {1'b0, spd}) << TICK_SHIFT;
    return CW'(p - (CW+1)'(1));
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_e                  state_q, state_d;
  logic [CW-1:0]           tick_q, tick_d;
  logic [CW-1:0]           pm1_q, pm1_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [15:0]             bc_q, bc_d;
  logic [15:0]             drain_q, drain_d;
  logic [3:0][CDW-1:0]     cd_q, cd_d;
  logic [3:0]              fire_q, fire_d;

  logic active;
  logic tick_en;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    pm1_d   = pm1_q;
    lfsr_d  = lfsr_q;
    bc_d    = bc_q;
    drain_d = drain_q;
    cd_d    = cd_q;
    fire_d  = '0;

    active  = (state_q == S_RUN) || (state_q == S_DRAIN);
    tick_en = active && !pause && (tick_q == pm1_q);

    // The new period is sampled only at a reload, so a speed change
    // never stretches or truncates the period already in progress.
    if (active && !pause) begin
      if (tick_en) begin
        tick_d = '0;
        pm1_d  = period_m1(speed);
      end else begin
        tick_d = tick_q + CW'(1);
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          tick_d  = '0;
          pm1_d   = period_m1(speed);
          lfsr_d  = SEED_EFF;
          bc_d    = '0;
          drain_d = '0;
          cd_d    = '0;
        end
      end
      S_RUN: begin
        if (tick_en) begin
          for (int k = 0; k < 4; k++) begin
            if (({1'b0, lfsr_q[4*k +: 4]} < DENS) && (cd_q[k] == '0)) begin
              fire_d[k] = 1'b1;
              cd_d[k]   = GAP;
            end else if (cd_q[k] != '0) begin
              cd_d[k] = cd_q[k] - CDW'(1);
            end
          end
          lfsr_d = lfsr_next(lfsr_q);
          if (bc_q != NB) begin
            bc_d = bc_q + 16'd1;
          end
          if (bc_q + 16'd1 == NB) begin
            state_d = (DRAIN_TICKS == 0) ? S_DONE : S_DRAIN;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (tick_en) begin
          drain_d = drain_q + 16'd1;
          if (drain_q + 16'd1 == DT) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage boundary: all state, with fire flags delayed one cycle past en.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      pm1_q   <= '0;
      lfsr_q  <= SEED_EFF;
      bc_q    <= '0;
      drain_q <= '0;
      cd_q    <= '0;
      fire_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      pm1_q   <= pm1_d;
      lfsr_q  <= lfsr_d;
      bc_q    <= bc_d;
      drain_q <= drain_d;
      cd_q    <= cd_d;
      fire_q  <= fire_d;
    end
  end

  assign en         = tick_en;
  assign r1         = fire_q[0];
  assign r2         = fire_q[1];
  assign r3         = fire_q[2];
  assign r4         = fire_q[3];
  assign busy       = active;
  assign done       = (state_q == S_DONE);
  assign beat_count = bc_q;

endmodule

// File: tb/tb_note_spawner.sv
// Testbench for note_spawner: behavioural song model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_note_spawner;

  localparam int          TS   = 0;
  localparam logic [15:0] SD   = 16'hACE1;
  localparam int          DEN  = 4;
  localparam int          GAPP = 1;
  localparam int          NB   = 3;
  localparam int          DT   = 8;

  logic        clk = 1'b0;
  logic        reset, start, pause;
  logic [9:0]  speed;
  logic        en, r1, r2, r3, r4, busy, done;
  logic [15:0] beat_count;

  note_spawner #(
    .TICK_SHIFT (TS),
    .SEED       (SD),
    .DENSITY    (DEN),
    .MIN_GAP    (GAPP),
    .NUM_BEATS  (NB),
    .DRAIN_TICKS(DT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .speed     (speed),
    .en        (en),
    .r1        (r1),
    .r2        (r2),
    .r3        (r3),
    .r4        (r4),
    .busy      (busy),
    .done      (done),
    .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_PLAY = 1, M_FLUSH = 2, M_OVER = 3;

  int          m_mode;
  int          m_cnt;
  int          m_per;
  logic [15:0] m_lfsr;
  int          m_cd[4];
  int          m_beats;
  int          m_flush;
  logic [3:0]  m_r;
  bit          started = 0;

  function automatic int period_of(input logic [9:0] s);
    return (1024 - int'(s)) << TS;
  endfunction

  function automatic logic [15:0] shift_lfsr(input logic [15:0] v);
    int x, fb;
    x  = int'(v);
    fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
    return 16'(((x << 1) | fb) & 32'hFFFF);
  endfunction

  function automatic bit model_en(input logic p);
    return (m_mode == M_PLAY || m_mode == M_FLUSH) && !p && (m_cnt == m_per - 1);
  endfunction

  initial begin
    forever begin
      bit e;
      int nib;
      @(posedge clk);
      e = model_en(pause);
      if (reset) begin
        m_mode = M_IDLE; m_cnt = 0; m_per = 1; m_lfsr = SD;
        m_beats = 0; m_flush = 0; m_r = 4'b0;
        for (int k = 0; k < 4; k++) m_cd[k] = 0;
      end else begin
        m_r = 4'b0;
        if (m_mode == M_IDLE || m_mode == M_OVER) begin
          if (start) begin
            m_mode = M_PLAY; m_cnt = 0; m_per = period_of(speed);
            m_lfsr = SD; m_beats = 0;
            for (int k = 0; k < 4; k++) m_cd[k] = 0;
          end
        end else begin
          if (!pause) begin
            if (e) begin m_cnt = 0; m_per = period_of(speed); end
            else m_cnt++;
          end
          if (e && m_mode == M_PLAY) begin
            for (int k = 0; k < 4; k++) begin
              nib = (int'(m_lfsr) >> (4 * k)) & 15;
              if (nib < DEN && m_cd[k] == 0) begin
                m_r[k]  = 1'b1;
                m_cd[k] = GAPP;
              end else if (m_cd[k] > 0) begin
                m_cd[k]--;
              end
            end
            m_lfsr = shift_lfsr(m_lfsr);
            m_beats++;
            if (m_beats == NB) begin m_mode = M_FLUSH; m_flush = 0; end
          end else if (e && m_mode == M_FLUSH) begin
            m_flush++;
            if (m_flush == DT) m_mode = M_OVER;
          end
        end
      end
      started = 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("cycle",
          {9'b0, en, r4, r3, r2, r1, busy, done, beat_count},
          {9'b0, model_en(pause), m_r,
           (m_mode == M_PLAY || m_mode == M_FLUSH),
           (m_mode == M_OVER), 16'(m_beats)});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (en !== 1'b1 && n < 100);
    chk({nm, "_seen"}, {31'b0, en}, 32'd1);
  endtask

  initial begin
    int n, n_en, cnt_en;
    logic [12:0] en_pat;
    logic [3:0]  r_h[14];
    logic [15:0] bc13;

    reset = 1'b1; start = 1'b0; pause = 1'b0; speed = 10'd1020;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_out", {9'b0, en, r4, r3, r2, r1, busy, done, beat_count}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Song 1: P = 4, en at cycles 4, 8, 12 after RUN entry.
    start = 1'b1;
    tick();
    start = 1'b0;
    en_pat = '0;
    bc13 = '0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      en_pat[k-1] = en;
      r_h[k] = {r4, r3, r2, r1};
      if (k == 1) chk("busy_run", {31'b0, busy}, 32'd1);
      if (k == 13) bc13 = beat_count;
    end
    chk("en_sched", {19'b0, en_pat}, 32'h0888);
    chk("r_beat1", {28'b0, r_h[5]}, 32'h1);
    chk("r_beat2", {28'b0, r_h[9]}, 32'h0);
    chk("r_beat3", {28'b0, r_h[13]}, 32'h4);
    chk("bc_after3", {16'b0, bc13}, 32'd3);

    n_en = 3;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (done !== 1'b1 && en === 1'b1) n_en++;
    end
    chk("en_total", n_en, 32'd11);
    chk("done_level", {31'b0, done}, 32'd1);
    cnt_en = 0;
    repeat (10) begin
      @(negedge clk);
      if (en === 1'b1) cnt_en++;
    end
    chk("en_after_done", cnt_en, 32'd0);
    chk("bc_hold", {16'b0, beat_count}, 32'd3);

    // Song 2: start with pause high, then pause and speed change mid-period.
    tick();
    start = 1'b1; pause = 1'b1;
    tick();
    start = 1'b0;
    cnt_en = 0;
    repeat (3) begin
      @(negedge clk);
      if (en === 1'b1) cnt_en++;
    end
    chk("paused_en", cnt_en, 32'd0);
    chk("paused_busy", {31'b0, busy}, 32'd1);
    tick();
    pause = 1'b0;
    wait_en("restart", n);
    chk("restart_p", n, 32'd4);
    @(negedge clk);
    chk("restart_pattern", {28'b0, r4, r3, r2, r1}, 32'h1);
    chk("bc1", {16'b0, beat_count}, 32'd1);
    tick();
    pause = 1'b1;
    cnt_en = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (en === 1'b1) cnt_en++;
      if (i == 9) chk("pause_bc", {16'b0, beat_count}, 32'd1);
    end
    chk("pause_en", cnt_en, 32'd0);
    tick();
    pause = 1'b0;
    wait_en("resume", n);
    chk("pause_resume", n, 32'd3);
    tick();
    tick();
    speed = 10'd1022;
    wait_en("spd_a", n);
    chk("speed_cur", n, 32'd3);
    wait_en("spd_b", n);
    chk("speed_next", n, 32'd2);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done2", {31'b0, done}, 32'd1);

    // Song 3: reset between en and its r pulse.
    speed = 10'd1020;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_en("rst_en", n);
    chk("rst_p", n, 32'd4);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_clear", {9'b0, en, r4, r3, r2, r1, busy, done, beat_count}, 32'd0);
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_en("post_rst", n);
    @(negedge clk);
    chk("post_reset_pattern", {28'b0, r4, r3, r2, r1}, 32'h1);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
